// File: rtl/kv_pkg.sv
// Shared definitions for the key-value store Wishbone initiator: op codes,
// FSM states, select encodings and a saturating counter helper.
package kv_pkg;

  typedef enum logic [1:0] {
    KV_OP_PUT  = 2'd0,
    KV_OP_GET  = 2'd1,
    KV_OP_RGET = 2'd2,
    KV_OP_RSVD = 2'd3
  } kv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } kv_state_e;

  localparam logic [3:0] KV_SEL_ADR_KEY = 4'b0001;
  localparam logic [3:0] KV_SEL_DAT_KEY = 4'b0010;

  function automatic logic [7:0] kv_sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/kv_ack_timer.sv
// Counts bus cycles spent waiting for ACK; expired_o flags the final
// permitted cycle so the FSM can abandon the transfer on that edge.
module kv_ack_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = 8'd0;
    else if (en_i) cnt_d = cnt_q + 8'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  end

  // The count reads k-1 during the k-th waiting cycle.
  assign expired_o = (cnt_q == LIMIT - 8'd1);

endmodule

// File: rtl/kv_wb_initiator.sv
// Wishbone classic initiator for the 16-bit key-value store: one command in,
// one registered single-beat bus cycle out, one response back.
module kv_wb_initiator
  import kv_pkg::*;
#(
  parameter logic [15:0] BASE_ADR = 16'h3000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [15:0] cmd_key_i,
  input  logic [15:0] cmd_val_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_data_o,
  output logic        rsp_dup_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [7:0]  err_cnt_o
);

  kv_state_e   state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] adr_q, adr_d;
  logic [15:0] dat_q, dat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_dup_q, rsp_dup_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        tmr_clr, tmr_expired;
  logic        unused_dat_hi;

  assign unused_dat_hi = ^wbm_dat_i[31:17];

  kv_ack_timer #(.LIMIT(8'(TIMEOUT))) u_ack_timer (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .clr_i     (tmr_clr),
    .en_i      (state_q == BUS),
    .expired_o (tmr_expired)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_dup_d   = rsp_dup_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    tmr_clr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          if (kv_op_e'(cmd_op_i) == KV_OP_RSVD) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 16'h0;
            rsp_dup_d   = 1'b0;
            err_cnt_d   = kv_sat_inc(err_cnt_q);
            state_d     = RESP;
          end else begin
            tmr_clr = 1'b1;
            cyc_d   = 1'b1;
            state_d = BUS;
            unique case (kv_op_e'(cmd_op_i))
              KV_OP_PUT: begin
                we_d  = 1'b1;
                sel_d = KV_SEL_ADR_KEY;
                adr_d = cmd_key_i;
                dat_d = cmd_val_i;
              end
              KV_OP_GET: begin
                we_d  = 1'b0;
                sel_d = KV_SEL_ADR_KEY;
                adr_d = cmd_key_i;
                dat_d = 16'h0;
              end
              default: begin
                // Reverse lookup: the value travels on the data bus.
                we_d  = 1'b0;
                sel_d = KV_SEL_DAT_KEY;
                adr_d = 16'h0;
                dat_d = cmd_key_i;
              end
            endcase
          end
        end
      end

      BUS: begin
        if (wbm_ack_i || tmr_expired) begin
          // ACK takes priority over a coincident timer expiry.
          rsp_valid_d = 1'b1;
          rsp_err_d   = !wbm_ack_i;
          rsp_data_d  = wbm_ack_i ? wbm_dat_i[15:0] : 16'h0;
          rsp_dup_d   = wbm_ack_i ? wbm_dat_i[16]   : 1'b0;
          if (!wbm_ack_i) err_cnt_d = kv_sat_inc(err_cnt_q);
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'h0;
          adr_d   = 16'h0;
          dat_d   = 16'h0;
          state_d = RESP;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 16'h0;
      dat_q       <= 16'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0;
      rsp_dup_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= 8'h0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_dup_q   <= rsp_dup_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_dup_o   = rsp_dup_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = {BASE_ADR, adr_q};
  assign wbm_dat_o   = {16'h0, dat_q};
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_kv_wb_initiator.sv
// Directed bench for kv_wb_initiator with a hand-driven Wishbone responder.
module tb_kv_wb_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_key = 16'h0;
  logic [15:0] cmd_val = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_dup;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic        ack = 1'b0;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kv_wb_initiator #(.BASE_ADR(16'h3000), .TIMEOUT(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_key_i   (cmd_key),
    .cmd_val_i   (cmd_val),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_dup_o   (rsp_dup),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat_o),
    .wbm_dat_i   (dat_i),
    .wbm_ack_i   (ack),
    .err_cnt_o   (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs and samples live 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] key, input logic [15:0] val);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_key   = key;
    cmd_val   = val;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int  stb_cycles;
    bit  saw_cyc;

    // Reset state
    step();
    check("rst_cyc",   {31'h0, cyc},       32'h0);
    check("rst_stb",   {31'h0, stb},       32'h0);
    check("rst_adr",   adr,                32'h3000_0000);
    check("rst_dat",   dat_o,              32'h0);
    check("rst_rdy",   {31'h0, cmd_ready}, 32'h0);
    check("rst_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_errc",  {24'h0, err_cnt},   32'h0);
    rst = 1'b0;
    step();
    check("post_rst_rdy", {31'h0, cmd_ready}, 32'h1);

    // PUT, ACK in the third bus cycle
    issue(2'd0, 16'h0042, 16'hBEEF);
    check("put_stb1", {31'h0, stb}, 32'h1);
    check("put_we",   {31'h0, we},  32'h1);
    check("put_sel",  {28'h0, sel}, 32'h1);
    check("put_adr",  adr,          32'h3000_0042);
    check("put_dat",  dat_o,        32'h0000_BEEF);
    check("put_rdy",  {31'h0, cmd_ready}, 32'h0);
    step();
    check("put_stb2", {31'h0, stb}, 32'h1);
    step();
    check("put_stb3", {31'h0, stb}, 32'h1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("put_stb_end", {31'h0, stb},       32'h0);
    check("put_valid",   {31'h0, rsp_valid}, 32'h1);
    check("put_err",     {31'h0, rsp_err},   32'h0);
    consume();
    check("put_valid_drop", {31'h0, rsp_valid}, 32'h0);
    check("put_rdy_back",   {31'h0, cmd_ready}, 32'h1);

    // GET with duplicate flag, response held under backpressure
    issue(2'd1, 16'h0042, 16'h5555);
    check("get_we",  {31'h0, we}, 32'h0);
    check("get_sel", {28'h0, sel}, 32'h1);
    check("get_adr", adr,          32'h3000_0042);
    check("get_dat", dat_o,        32'h0);
    ack   = 1'b1;
    dat_i = 32'h0001_BEEF;
    step();
    ack   = 1'b0;
    dat_i = 32'h0;
    check("get_stb_end", {31'h0, stb}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("get_hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("get_hold_data",  {16'h0, rsp_data},  32'h0000_BEEF);
      check("get_hold_dup",   {31'h0, rsp_dup},   32'h1);
      check("get_hold_rdy",   {31'h0, cmd_ready}, 32'h0);
      step();
    end
    consume();
    check("get_valid_drop", {31'h0, rsp_valid}, 32'h0);

    // RGET
    issue(2'd2, 16'hBEEF, 16'h0);
    check("rget_we",  {31'h0, we}, 32'h0);
    check("rget_sel", {28'h0, sel}, 32'h2);
    check("rget_adr", adr,          32'h3000_0000);
    check("rget_dat", dat_o,        32'h0000_BEEF);
    ack   = 1'b1;
    dat_i = 32'h0000_0042;
    step();
    ack   = 1'b0;
    dat_i = 32'h0;
    check("rget_valid", {31'h0, rsp_valid}, 32'h1);
    check("rget_data",  {16'h0, rsp_data},  32'h0000_0042);
    check("rget_dup",   {31'h0, rsp_dup},   32'h0);
    check("rget_err",   {31'h0, rsp_err},   32'h0);
    consume();

    // Timeout with no ACK
    issue(2'd1, 16'h0001, 16'h0);
    stb_cycles = 0;
    for (int i = 0; i < 12 && !rsp_valid; i++) begin
      if (stb) stb_cycles++;
      step();
    end
    check("to_stb_cycles", stb_cycles,           32'd4);
    check("to_valid",      {31'h0, rsp_valid},   32'h1);
    check("to_stb_low",    {31'h0, stb},         32'h0);
    check("to_err",        {31'h0, rsp_err},     32'h1);
    check("to_data",       {16'h0, rsp_data},    32'h0);
    check("to_dup",        {31'h0, rsp_dup},     32'h0);
    check("to_errcnt",     {24'h0, err_cnt},     32'd1);
    consume();

    // ACK coincides with the final permitted cycle
    issue(2'd1, 16'h0002, 16'h0);
    step();
    step();
    step();
    check("late_stb4", {31'h0, stb}, 32'h1);
    ack   = 1'b1;
    dat_i = 32'h0000_1234;
    step();
    ack   = 1'b0;
    dat_i = 32'h0;
    check("late_valid",  {31'h0, rsp_valid}, 32'h1);
    check("late_err",    {31'h0, rsp_err},   32'h0);
    check("late_data",   {16'h0, rsp_data},  32'h0000_1234);
    check("late_errcnt", {24'h0, err_cnt},   32'd1);
    consume();

    // Reserved op: immediate error response, no bus cycle
    issue(2'd3, 16'hAAAA, 16'hBBBB);
    check("rsvd_cyc",    {31'h0, cyc},       32'h0);
    check("rsvd_valid",  {31'h0, rsp_valid}, 32'h1);
    check("rsvd_err",    {31'h0, rsp_err},   32'h1);
    check("rsvd_data",   {16'h0, rsp_data},  32'h0);
    check("rsvd_errcnt", {24'h0, err_cnt},   32'd2);
    saw_cyc = 1'b0;
    for (int i = 0; i < 299; i++) begin
      consume();
      issue(2'd3, 16'(i), 16'h0);
      if (cyc || !rsp_valid) saw_cyc = 1'b1;
    end
    check("rsvd_loop_ok",  {31'h0, saw_cyc}, 32'h0);
    check("rsvd_errcnt_sat", {24'h0, err_cnt}, 32'd255);
    consume();

    // Asynchronous reset during a bus cycle
    issue(2'd0, 16'h0077, 16'h1111);
    check("mid_stb_pre", {31'h0, stb}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_stb",     {31'h0, stb},       32'h0);
    check("mid_cyc",     {31'h0, cyc},       32'h0);
    check("mid_valid",   {31'h0, rsp_valid}, 32'h0);
    check("mid_errcnt",  {24'h0, err_cnt},   32'h0);
    check("mid_adr",     adr,                32'h3000_0000);
    step();
    rst = 1'b0;
    step();
    check("mid_rdy_after", {31'h0, cmd_ready}, 32'h1);
    check("mid_valid_after", {31'h0, rsp_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
